// File: rtl/divisor_result_fifo.sv
// Result FIFO behind the pipelined divider: queues quotient/remainder pairs and flags overruns.
// Define DIVRES_DROPCNT_EN to add the saturating DROPS counter output.
module divisor_result_fifo #(
  parameter int unsigned tamanyo     = 8,
  parameter int unsigned profundidad = 4,
  parameter int unsigned AW          = $clog2(profundidad)
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               DONE_IN,
  input  logic [tamanyo-1:0] COC_IN,
  input  logic [tamanyo-1:0] RES_IN,
  input  logic               READY,
  input  logic               CLR_OVF,
  output logic               VALID,
  output logic [tamanyo-1:0] COC,
  output logic [tamanyo-1:0] RES,
  output logic [AW:0]        COUNT,
  output logic               FULL,
  output logic               EMPTY,
`ifdef DIVRES_DROPCNT_EN
  output logic [7:0]         DROPS,
`endif
  output logic               OVF
);

  localparam logic [AW:0] DepthCnt = (AW+1)'(profundidad);

  logic [2*tamanyo-1:0] mem_q [profundidad];
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 empty, full, pop, push, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);
  assign pop   = ~empty & READY;
  // The divider cannot stall, so a full FIFO only accepts when it pops in the same cycle.
  assign push  = DONE_IN & (~full | pop);
  assign drop  = DONE_IN & full & ~pop;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as the clear must still be reported.
    if (drop)         ovf_d = 1'b1;
    else if (CLR_OVF) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= {COC_IN, RES_IN};
  end

`ifdef DIVRES_DROPCNT_EN
  logic [7:0] drops_q, drops_d;

  always_comb begin
    drops_d = drops_q;
    if (drop) begin
      if (CLR_OVF)               drops_d = 8'd1;
      else if (drops_q != 8'hFF) drops_d = drops_q + 8'd1;
    end else if (CLR_OVF) begin
      drops_d = 8'd0;
    end
  end

  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) drops_q <= 8'd0;
    else      drops_q <= drops_d;
  end

  assign DROPS = drops_q;
`endif

  always_comb begin
    VALID = ~empty;
    COUNT = count_q;
    FULL  = full;
    EMPTY = empty;
    OVF   = ovf_q;
    COC   = '0;
    RES   = '0;
    if (!empty) begin
      COC = mem_q[rptr_q][2*tamanyo-1:tamanyo];
      RES = mem_q[rptr_q][tamanyo-1:0];
    end
  end

endmodule

// File: tb/tb_divisor_result_fifo.sv
// Directed bench for divisor_result_fifo with a queue scoreboard and a small occupancy model.
module tb_divisor_result_fifo;

  localparam int W = 8;
  localparam int D = 4;
  localparam int A = $clog2(D);

  logic         CLK = 1'b0;
  logic         RSTa = 1'b1;
  logic         DONE_IN = 1'b0;
  logic [W-1:0] COC_IN = '0;
  logic [W-1:0] RES_IN = '0;
  logic         READY = 1'b0;
  logic         CLR_OVF = 1'b0;
  logic         VALID, FULL, EMPTY, OVF;
  logic [W-1:0] COC, RES;
  logic [A:0]   COUNT;
`ifdef DIVRES_DROPCNT_EN
  logic [7:0]   DROPS;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [2*W-1:0] sb[$];
  logic           m_ovf = 1'b0;
  int             m_drops = 0;

  always #5 CLK = ~CLK;

  divisor_result_fifo #(.tamanyo(W), .profundidad(D)) dut (
    .CLK     (CLK),
    .RSTa    (RSTa),
    .DONE_IN (DONE_IN),
    .COC_IN  (COC_IN),
    .RES_IN  (RES_IN),
    .READY   (READY),
    .CLR_OVF (CLR_OVF),
    .VALID   (VALID),
    .COC     (COC),
    .RES     (RES),
    .COUNT   (COUNT),
    .FULL    (FULL),
    .EMPTY   (EMPTY),
`ifdef DIVRES_DROPCNT_EN
    .DROPS   (DROPS),
`endif
    .OVF     (OVF)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(VALID), 32'd0);
    chk({tag, "_empty"}, 32'(EMPTY), 32'd1);
    chk({tag, "_full"},  32'(FULL),  32'd0);
    chk({tag, "_count"}, 32'(COUNT), 32'd0);
    chk({tag, "_coc"},   32'(COC),   32'd0);
    chk({tag, "_res"},   32'(RES),   32'd0);
    chk({tag, "_ovf"},   32'(OVF),   32'd0);
  endtask

  // One clock cycle: drive inputs, check the head before the edge, update the model, check state after.
  task automatic cycle(input logic d, input logic [W-1:0] c, input logic [W-1:0] r,
                       input logic rd, input logic cl);
    int  sz;
    bit  pop, push, drop;
    DONE_IN = d; COC_IN = c; RES_IN = r; READY = rd; CLR_OVF = cl;
    #3;
    sz = sb.size();
    chk("valid", 32'(VALID), 32'(sz != 0));
    if (sz != 0) begin
      chk("head_coc", 32'(COC), 32'(sb[0][2*W-1:W]));
      chk("head_res", 32'(RES), 32'(sb[0][W-1:0]));
    end else begin
      chk("empty_coc", 32'(COC), 32'd0);
      chk("empty_res", 32'(RES), 32'd0);
    end
    pop  = (sz != 0) && rd;
    push = d && ((sz < D) || pop);
    drop = d && (sz == D) && !pop;
    if (pop)  void'(sb.pop_front());
    if (push) sb.push_back({c, r});
    if (drop)    m_ovf = 1'b1;
    else if (cl) m_ovf = 1'b0;
    if (drop)    m_drops = cl ? 1 : ((m_drops == 255) ? 255 : m_drops + 1);
    else if (cl) m_drops = 0;
    @(posedge CLK);
    #1;
    chk("count", 32'(COUNT), 32'(sb.size()));
    chk("full",  32'(FULL),  32'(sb.size() == D));
    chk("empty", 32'(EMPTY), 32'(sb.size() == 0));
    chk("ovf",   32'(OVF),   32'(m_ovf));
`ifdef DIVRES_DROPCNT_EN
    chk("drops", 32'(DROPS), 32'(m_drops));
`endif
    DONE_IN = 1'b0; READY = 1'b0; CLR_OVF = 1'b0;
  endtask

  initial begin
    #3;
    chk_reset_outputs("rst");
    @(posedge CLK); #1;
    RSTa = 1'b0;
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Single result then pop
    cycle(1'b1, 8'h0E, 8'h03, 1'b0, 1'b0);
    chk("single_coc", 32'(COC), 32'h0E);
    chk("single_res", 32'(RES), 32'h03);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("single_drained", 32'(EMPTY), 32'd1);

    // Burst fill
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 8'(8'h10 + i), 1'b0, 1'b0);
    chk("fill_full", 32'(FULL), 32'd1);

    // Overrun, head untouched, then clear
    cycle(1'b1, 8'h05, 8'h55, 1'b0, 1'b0);
    chk("ovr_ovf", 32'(OVF), 32'd1);
    chk("ovr_head", 32'(COC), 32'h01);
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", 32'(OVF), 32'd0);

    // Full + simultaneous write/read, then drain across the pointer wrap
    cycle(1'b1, 8'h09, 8'h99, 1'b1, 1'b0);
    chk("wr_rd_count", 32'(COUNT), 32'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

    // Empty + DONE_IN + READY: write only
    cycle(1'b1, 8'hA1, 8'h01, 1'b1, 1'b0);
    chk("empty_wr_rd", 32'(COUNT), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hB0 + i), 8'(i), 1'b0, 1'b0);

    // Drop and clear in the same cycle: set wins
    cycle(1'b1, 8'hCC, 8'hCC, 1'b0, 1'b1);
    chk("drop_clr_ovf", 32'(OVF), 32'd1);
    cycle(1'b1, 8'hCD, 8'hCD, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

    // Reset mid-burst with three entries stored
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + i), 8'(8'h07 + i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(COUNT), 32'd3);
    #2;
    RSTa = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    sb.delete();
    m_ovf = 1'b0;
    m_drops = 0;
    @(posedge CLK); #1;
    RSTa = 1'b0;
    cycle(1'b1, 8'h42, 8'h24, 1'b0, 1'b0);
    chk("post_rst_count", 32'(COUNT), 32'd1);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/divisor_result_fifo.md
Name: divisor_result_fifo

Overview:
Result buffer sitting directly downstream of the pipelined divider. Captures every quotient/remainder pair the divider flags with DONE and queues it in a small FIFO. Presents the results to the consumer through a valid/ready handshake. The divider pipeline has no backpressure, so this block is the only absorption point. Overruns are detected and flagged, never silently hidden.

Parameters:
tamanyo, 8, width of the quotient and remainder words (must match the divider)
profundidad, 4, FIFO depth in entries; power of two, minimum 2
AW, $clog2(profundidad), pointer width (derived; do not override)

Ports:
CLK  input  1  clock, rising edge
RSTa  input  1  asynchronous reset, active-high
DONE_IN  input  1  divider result strobe; one entry per cycle while high
COC_IN  input  tamanyo  quotient from the divider, valid when DONE_IN=1
RES_IN  input  tamanyo  remainder from the divider, valid when DONE_IN=1
READY  input  1  consumer accepts the head entry this cycle
CLR_OVF  input  1  synchronous clear of the OVF flag (and the drop counter, if built)
VALID  output  1  head entry available
COC  output  tamanyo  head quotient
RES  output  tamanyo  head remainder
COUNT  output  AW+1  number of stored entries, 0..profundidad
FULL  output  1  COUNT == profundidad
EMPTY  output  1  COUNT == 0
OVF  output  1  sticky flag: a result was dropped

Behaviour:
- Reset (RSTa=1, asynchronous): read/write pointers=0, COUNT=0, OVF=0, VALID=0, EMPTY=1, FULL=0, COC=0, RES=0. Storage array is not reset.
- Write: when DONE_IN=1 and (FULL=0 or a read occurs in the same cycle), {COC_IN,RES_IN} is stored at wptr on the rising edge, then wptr increments.
- Read: the pop condition is VALID & READY, evaluated on the rising edge, then rptr increments. READY while VALID=0 is ignored.
- Show-ahead: COC/RES combinationally reflect mem[rptr] while VALID=1. They are forced to 0 while EMPTY=1.
- VALID = ~EMPTY, registered via COUNT. An entry written at edge k is visible (VALID=1) from edge k until popped. Latency is 1 cycle, with no bypass from DONE_IN to the outputs.
- Pointers wrap modulo profundidad (natural AW-bit overflow).
- COUNT updates:
  - write only: +1
  - read only: -1
  - both: unchanged
  - neither: unchanged
- Full + DONE_IN + pop in the same cycle: both happen, no drop, COUNT stays profundidad.
- Full + DONE_IN without pop: the incoming result is discarded, storage and pointers are untouched, and OVF is set at that edge.
- Empty + DONE_IN + READY: write only. The pop is ignored because VALID=0.
- OVF is sticky until CLR_OVF=1. If CLR_OVF and a new drop occur in the same cycle, the set wins (OVF=1).
- FIFO ordering is strict: results emerge in divider completion order.
- Reset asserted mid-operation discards all contents immediately. Divider results arriving after reset release are queued normally.

Optional Feature:
Macro DIVRES_DROPCNT_EN.
- Defined: adds output port DROPS (8 bits, reset 0). DROPS increments on every dropped result, saturates at 255, and is cleared by CLR_OVF. A same-cycle drop with CLR_OVF leaves DROPS=1.
- Not defined: the DROPS port and its counter do not exist; only OVF reports overruns.

Test Plan:
- Reset then idle: RSTa pulse -> VALID=0, EMPTY=1, COUNT=0, COC=0, RES=0, OVF=0.
- Single result: DONE_IN=1 for 1 cycle with COC_IN=8'h0E, RES_IN=8'h03, READY=0 -> next cycle VALID=1, COC=0E, RES=03, COUNT=1. Raising READY for 1 cycle then gives EMPTY=1.
- Burst fill (profundidad=4): 4 consecutive DONE_IN with COC_IN=1,2,3,4, READY=0 -> FULL=1, COUNT=4. Popping then yields 1,2,3,4 in order.
- Overrun: with the FIFO full, a 5th DONE_IN (COC_IN=5) without READY -> OVF=1, COUNT=4, and the head stays 1. With DIVRES_DROPCNT_EN, DROPS=1. CLR_OVF pulse -> OVF=0 (DROPS=0).
- Full + simultaneous write/read: DONE_IN=1 with COC_IN=9 and READY=1 while full -> OVF stays 0, COUNT stays 4. The sequence out ends with 9 after the prior entries, confirming pointer wrap.
- Reset mid-burst: assert RSTa while COUNT=3 -> outputs return to reset values immediately. A DONE_IN after release gives COUNT=1.
